// File: rtl/id_stage_pkg.sv
// Shared constants for the instruction-decode stage: widths, opcode values,
// instruction field positions and the per-opcode control decode.
package id_stage_pkg;

    localparam int DSIZE  = 16;
    localparam int ASIZE  = 4;
    localparam int OPSIZE = 4;

    // Instruction field bit positions: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 0;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_NOP  = 4'd15;

    // Opcode value loaded into ID/EX whenever a bubble is inserted
    localparam logic [3:0] BUBBLE_OP = 4'hF;

    // Control bits derived from the opcode alone
    typedef struct packed {
        logic use_rs;    // reads rs through port 1
        logic use_rt;    // reads a second register through port 2
        logic rt_is_rd;  // second source is [11:8] (SW data, BEQ compare)
        logic wen;       // writes the register file
        logic memrd;     // load
        logic memwr;     // store
        logic illegal;   // reserved opcode 9..14
    } decode_t;

    function automatic decode_t decode_op(input logic [3:0] op);
        decode_t d;
        d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
                d.wen    = 1'b1;
            end
            OP_ADDI: begin
                d.use_rs = 1'b1;
                d.wen    = 1'b1;
            end
            OP_LW: begin
                d.use_rs = 1'b1;
                d.wen    = 1'b1;
                d.memrd  = 1'b1;
            end
            OP_SW: begin
                d.use_rs   = 1'b1;
                d.use_rt   = 1'b1;
                d.rt_is_rd = 1'b1;
                d.memwr    = 1'b1;
            end
            OP_BEQ: begin
                d.use_rs   = 1'b1;
                d.use_rt   = 1'b1;
                d.rt_is_rd = 1'b1;
            end
            OP_NOP: begin
                d = '0;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_hazard.sv
// Load-use hazard detector: flags an instruction in ID that reads the
// destination of a load currently sitting in ID/EX. Purely combinational.
module id_hazard #(
    parameter int ASIZE = 4
) (
    input  logic [ASIZE-1:0] rs,
    input  logic [ASIZE-1:0] rt_field,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             ex_valid,
    input  logic             ex_memrd,
    input  logic [ASIZE-1:0] ex_rd,
    output logic             haz
);

    // Compare the load destination with every source the ID instruction reads
    always_comb begin
        haz = ex_valid & ex_memrd &
              ((use_rs & (ex_rd == rs)) | (use_rt & (ex_rd == rt_field)));
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: drives register-file read addresses, decodes the
// opcode, sign-extends imm4, stalls on load-use hazards and owns the ID/EX
// pipeline register. Optional stall counter enabled by IDSTG_STALL_CNT_EN.
module id_stage #(
    parameter int DSIZE  = id_stage_pkg::DSIZE,
    parameter int ASIZE  = id_stage_pkg::ASIZE,
    parameter int OPSIZE = id_stage_pkg::OPSIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [15:0]       id_instr,
    output logic [ASIZE-1:0]  raddr1,
    output logic [ASIZE-1:0]  raddr2,
    input  logic [DSIZE-1:0]  rdata1,
    input  logic [DSIZE-1:0]  rdata2,
    input  logic              ex_flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [OPSIZE-1:0] ex_op,
    output logic [ASIZE-1:0]  ex_rd,
    output logic [DSIZE-1:0]  ex_a,
    output logic [DSIZE-1:0]  ex_b,
    output logic [DSIZE-1:0]  ex_imm,
    output logic              ex_wen,
    output logic              ex_memrd,
    output logic              ex_memwr,
    output logic              ex_illegal
`ifdef IDSTG_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    import id_stage_pkg::*;

    logic [OPSIZE-1:0] op_s;
    logic [ASIZE-1:0]  rd_field_s;
    logic [ASIZE-1:0]  rs_field_s;
    logic [ASIZE-1:0]  rt_field_s;
    logic [DSIZE-1:0]  imm_s;
    decode_t           dec_s;
    logic              use_rs_s;
    logic              use_rt_s;
    logic              haz_s;

    assign op_s       = id_instr[OP_MSB:OP_LSB];
    assign rd_field_s = id_instr[RD_MSB:RD_LSB];
    assign rs_field_s = id_instr[RS_MSB:RS_LSB];
    assign imm_s      = {{(DSIZE-4){id_instr[RT_MSB]}}, id_instr[RT_MSB:RT_LSB]};

    // Opcode decode into control bits
    always_comb begin
        dec_s = decode_op(op_s);
    end

    // Second read port takes [11:8] for SW/BEQ, [3:0] for everything else
    always_comb begin
        if (dec_s.rt_is_rd) begin
            rt_field_s = rd_field_s;
        end else begin
            rt_field_s = id_instr[RT_MSB:RT_LSB];
        end
    end

    assign raddr1 = rs_field_s;
    assign raddr2 = rt_field_s;

    // An empty IF/ID slot reads nothing, so it can never create a hazard
    assign use_rs_s = id_valid & dec_s.use_rs;
    assign use_rt_s = id_valid & dec_s.use_rt;

    id_hazard #(
        .ASIZE (ASIZE)
    ) u_hazard (
        .rs       (rs_field_s),
        .rt_field (rt_field_s),
        .use_rs   (use_rs_s),
        .use_rt   (use_rt_s),
        .ex_valid (ex_valid),
        .ex_memrd (ex_memrd),
        .ex_rd    (ex_rd),
        .haz      (haz_s)
    );

    // A flush kills the ID instruction anyway, so there is nothing to hold
    assign id_stall = haz_s & ~ex_flush;

    // ID/EX register: reset > flush > hazard bubble > empty slot > load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid   <= 1'b0;
            ex_op      <= BUBBLE_OP;
            ex_rd      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_wen     <= 1'b0;
            ex_memrd   <= 1'b0;
            ex_memwr   <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (ex_flush || haz_s || !id_valid) begin
            // bubble: data fields are held, only the control view is cleared
            ex_valid   <= 1'b0;
            ex_op      <= BUBBLE_OP;
            ex_wen     <= 1'b0;
            ex_memrd   <= 1'b0;
            ex_memwr   <= 1'b0;
            ex_illegal <= 1'b0;
        end else begin
            ex_valid   <= 1'b1;
            ex_op      <= op_s;
            ex_rd      <= rd_field_s;
            ex_a       <= rdata1;
            ex_b       <= rdata2;
            ex_imm     <= imm_s;
            ex_wen     <= dec_s.wen;
            ex_memrd   <= dec_s.memrd;
            ex_memwr   <= dec_s.memwr;
            ex_illegal <= dec_s.illegal;
        end
    end

`ifdef IDSTG_STALL_CNT_EN
    // Saturating count of cycles in which IF was held for a load-use hazard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'h0000;
        end else if (id_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule
